// File: rtl/tuner_pitch_meter_if.sv
// Bundle between the codec read path / display logic and the pitch meter.
// master drives sample stream and target settings, slave returns the measurement.
interface tuner_pitch_meter_if #(
  parameter int SAMPLE_W = 24,
  parameter int FREQ_W   = 16
);
  logic                enable;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [FREQ_W-1:0]   expected_freq;
  logic [FREQ_W-1:0]   tolerance;
  logic [FREQ_W-1:0]   freq;
  logic                freq_valid;
  logic                settled;
  logic                match;
  logic                greater;

  modport master (
    output enable, sample_valid, sample, expected_freq, tolerance,
    input  freq, freq_valid, settled, match, greater
  );

  modport slave (
    input  enable, sample_valid, sample, expected_freq, tolerance,
    output freq, freq_valid, settled, match, greater
  );
endinterface

// File: rtl/tuner_pitch_meter.sv
// Zero-crossing pitch meter: gated crossing count, scaled to Hz, smoothed by a
// moving average and compared against a target frequency with tolerance.
module tuner_pitch_meter #(
  parameter int                  SAMPLE_W    = 24,
  parameter int                  FREQ_W      = 16,
  parameter int                  SAMPLE_RATE = 48000,
  parameter int                  GATE_SHIFT  = 2,
  parameter logic [SAMPLE_W-1:0] HYST        = 24'd4096,
  parameter int                  AVG_LOG2    = 2
) (
  input logic               clk,
  input logic               reset,
  tuner_pitch_meter_if.slave bus
);
  localparam int GATE_LEN = SAMPLE_RATE >> GATE_SHIFT;
  localparam int CNT_W    = $clog2(GATE_LEN + 1);
  localparam int DEPTH    = 1 << AVG_LOG2;
  localparam int PTR_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILL_W   = $clog2(DEPTH + 1);
  localparam int SUM_W    = FREQ_W + AVG_LOG2;
  localparam int RAW_W    = CNT_W + GATE_SHIFT;
  localparam int WIDE_W   = ((RAW_W > FREQ_W) ? RAW_W : FREQ_W) + 1;

  localparam logic signed [SAMPLE_W-1:0] POS_HYST = $signed(HYST);
  localparam logic signed [SAMPLE_W-1:0] NEG_HYST = -$signed(HYST);

  typedef enum logic {SIGN_LOW, SIGN_HIGH} sign_t;

  sign_t             sign_reg, sign_next;
  logic              rise;
  logic              accept;
  logic              closing;
  logic [CNT_W-1:0]  sample_cnt_reg;
  logic [CNT_W-1:0]  cross_cnt_reg;
  logic [CNT_W-1:0]  cross_inc;
  logic [WIDE_W-1:0] raw_wide;
  logic [FREQ_W-1:0] raw;

  logic [FREQ_W-1:0] ring_reg [DEPTH];
  logic [FREQ_W-1:0] old_slot;
  logic [SUM_W-1:0]  sum_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [FILL_W-1:0] fill_reg;
  logic              upd_reg;

  logic [FREQ_W-1:0] freq_avg;
  logic [FREQ_W-1:0] diff;
  logic [FREQ_W-1:0] freq_reg;
  logic              freq_valid_reg;
  logic              settled_reg;
  logic              match_reg;
  logic              greater_reg;

  assign accept  = bus.enable & bus.sample_valid;
  assign closing = accept && (sample_cnt_reg == CNT_W'(GATE_LEN - 1));

  // Sign tracker with hysteresis; only LOW->HIGH edges are counted
  always_ff @(posedge clk) begin
    if (reset) sign_reg <= SIGN_LOW;
    else       sign_reg <= sign_next;
  end

  always_comb begin
    sign_next = sign_reg;
    rise      = 1'b0;
    if (!bus.enable) begin
      sign_next = SIGN_LOW;
    end else if (bus.sample_valid) begin
      case (sign_reg)
        SIGN_LOW: begin
          if ($signed(bus.sample) > POS_HYST) begin
            sign_next = SIGN_HIGH;
            rise      = 1'b1;
          end
        end
        SIGN_HIGH: begin
          if ($signed(bus.sample) < NEG_HYST) sign_next = SIGN_LOW;
        end
        default: sign_next = SIGN_LOW;
      endcase
    end
  end

  // Crossing count including the current strobe, so the closing sample is credited
  assign cross_inc = (rise && (cross_cnt_reg != '1)) ? cross_cnt_reg + CNT_W'(1) : cross_cnt_reg;
  assign raw_wide  = WIDE_W'(cross_inc) << GATE_SHIFT;
  assign raw       = (raw_wide > WIDE_W'({FREQ_W{1'b1}})) ? {FREQ_W{1'b1}} : raw_wide[FREQ_W-1:0];

  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      sample_cnt_reg <= '0;
      cross_cnt_reg  <= '0;
    end else if (accept) begin
      if (closing) begin
        sample_cnt_reg <= '0;
        cross_cnt_reg  <= '0;
      end else begin
        sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
        cross_cnt_reg  <= cross_inc;
      end
    end
  end

  // Averaging ring: one register per slot so reset can clear it
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ring
      always_ff @(posedge clk) begin
        if (reset)                                  ring_reg[gi] <= '0;
        else if (closing && ptr_reg == PTR_W'(gi)) ring_reg[gi] <= raw;
      end
    end
  endgenerate

  assign old_slot = ring_reg[ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg  <= '0;
      ptr_reg  <= '0;
      fill_reg <= '0;
      upd_reg  <= 1'b0;
    end else begin
      upd_reg <= closing;
      if (closing) begin
        sum_reg <= sum_reg - SUM_W'(old_slot) + SUM_W'(raw);
        ptr_reg <= (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
        if (fill_reg != FILL_W'(DEPTH)) fill_reg <= fill_reg + FILL_W'(1);
      end
    end
  end

  assign freq_avg = sum_reg[SUM_W-1:AVG_LOG2];
  assign diff     = (freq_avg >= bus.expected_freq) ? freq_avg - bus.expected_freq
                                                    : bus.expected_freq - freq_avg;

  // Results are latched only on an update; target changes alone do not re-evaluate
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_reg       <= '0;
      freq_valid_reg <= 1'b0;
      settled_reg    <= 1'b0;
      match_reg      <= 1'b0;
      greater_reg    <= 1'b0;
    end else begin
      freq_valid_reg <= upd_reg;
      if (upd_reg) begin
        freq_reg    <= freq_avg;
        settled_reg <= (fill_reg == FILL_W'(DEPTH));
        match_reg   <= (diff <= bus.tolerance);
        greater_reg <= (freq_avg >= bus.expected_freq);
      end
    end
  end

  assign bus.freq       = freq_reg;
  assign bus.freq_valid = freq_valid_reg;
  assign bus.settled    = settled_reg;
  assign bus.match      = match_reg;
  assign bus.greater    = greater_reg;
endmodule

// File: tb/tb_tuner_pitch_meter.sv
// Scoreboard bench for tuner_pitch_meter on a scaled-down gate (120 samples per window).
module tb_tuner_pitch_meter;
  localparam int SAMPLE_W    = 24;
  localparam int FREQ_W      = 16;
  localparam int SAMPLE_RATE = 480;
  localparam int GATE_SHIFT  = 2;
  localparam int AVG_LOG2    = 2;
  localparam int GATE_LEN    = 120;
  localparam int DEPTH       = 4;
  localparam int HYST        = 4096;
  localparam int CROSS_MAX   = 127;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tuner_pitch_meter_if #(.SAMPLE_W(SAMPLE_W), .FREQ_W(FREQ_W)) bus_if ();

  tuner_pitch_meter #(
    .SAMPLE_W(SAMPLE_W), .FREQ_W(FREQ_W), .SAMPLE_RATE(SAMPLE_RATE),
    .GATE_SHIFT(GATE_SHIFT), .HYST(24'd4096), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  typedef struct {
    int cyc;
    int freq;
    bit settled;
    bit match;
    bit greater;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_fv  = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  bit m_high;
  int m_samp, m_cross, m_sum, m_ptr, m_fill;
  int m_ring[DEPTH];

  function automatic logic [23:0] sq(input int j, input int p, input int off);
    logic [23:0] v;
    v = (((j + off) % p) < (p / 2)) ? 24'(8000000) : 24'(-8000000);
    return v;
  endfunction

  function automatic logic [23:0] tri_wave(input int j);
    int ph, v;
    ph = j % 24;
    v  = (ph < 12) ? (-2000 + ph * 333) : (2000 - (ph - 12) * 333);
    return 24'(v);
  endfunction

  task automatic model_reset();
    m_high = 0; m_samp = 0; m_cross = 0; m_sum = 0; m_ptr = 0; m_fill = 0;
    for (int i = 0; i < DEPTH; i++) m_ring[i] = 0;
    sb.delete();
  endtask

  task automatic model_accept(input logic [23:0] s);
    int sv, raw, diff, ef;
    exp_t e;
    sv = int'($signed(s));
    if (!m_high && sv > HYST) begin
      m_high = 1;
      if (m_cross < CROSS_MAX) m_cross++;
    end else if (m_high && sv < -HYST) begin
      m_high = 0;
    end
    m_samp++;
    if (m_samp == GATE_LEN) begin
      raw = m_cross * (1 << GATE_SHIFT);
      if (raw > 65535) raw = 65535;
      m_sum = m_sum - m_ring[m_ptr] + raw;
      m_ring[m_ptr] = raw;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_fill < DEPTH) m_fill++;
      ef = int'(bus_if.expected_freq);
      e.cyc     = cyc + 2;
      e.freq    = m_sum / DEPTH;
      e.settled = (m_fill == DEPTH);
      diff      = (e.freq >= ef) ? e.freq - ef : ef - e.freq;
      e.match   = (diff <= int'(bus_if.tolerance));
      e.greater = (e.freq >= ef);
      sb.push_back(e);
      m_samp = 0;
      m_cross = 0;
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        n_vec++; n_err++;
        $display("FAIL missing_pulse cyc=%0d no freq_valid, required at cyc=%0d freq=%0d", cyc, e.cyc, e.freq);
      end
      if (bus_if.freq_valid) begin
        n_fv++;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_pulse cyc=%0d freq=%0d, required no freq_valid", cyc, bus_if.freq);
        end else begin
          e = sb.pop_front();
          $display("txn cyc=%0d freq=%0d settled=%0b match=%0b greater=%0b", cyc, bus_if.freq,
                   bus_if.settled, bus_if.match, bus_if.greater);
          n_vec++;
          if (cyc !== e.cyc) begin
            n_err++; $display("FAIL pulse_cycle got=%0d required=%0d", cyc, e.cyc);
          end
          n_vec++;
          if (bus_if.freq !== 16'(e.freq)) begin
            n_err++; $display("FAIL sb_freq got=%0d required=%0d", bus_if.freq, e.freq);
          end
          n_vec++;
          if (bus_if.settled !== e.settled) begin
            n_err++; $display("FAIL sb_settled got=%0b required=%0b", bus_if.settled, e.settled);
          end
          n_vec++;
          if (bus_if.match !== e.match) begin
            n_err++; $display("FAIL sb_match got=%0b required=%0b", bus_if.match, e.match);
          end
          n_vec++;
          if (bus_if.greater !== e.greater) begin
            n_err++; $display("FAIL sb_greater got=%0b required=%0b", bus_if.greater, e.greater);
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [23:0] s, input int gap);
    @(negedge clk);
    bus_if.sample       = s;
    bus_if.sample_valid = 1'b1;
    if (bus_if.enable) model_accept(s);
    for (int k = 1; k < gap; k++) begin
      @(negedge clk);
      bus_if.sample_valid = 1'b0;
    end
  endtask

  // kind: 0 square(p, off), 1 sub-hysteresis triangle
  task automatic run_samples(input int n, input int kind, input int p, input int off, input int gap);
    for (int j = 0; j < n; j++) drive((kind == 0) ? sq(j, p, off) : tri_wave(j), gap);
    @(negedge clk);
    bus_if.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    n_vec++; if (bus_if.freq !== 16'd0) begin n_err++; $display("FAIL reset_freq got=%0d required=0", bus_if.freq); end
    n_vec++; if (bus_if.freq_valid !== 1'b0) begin n_err++; $display("FAIL reset_freq_valid got=%0b required=0", bus_if.freq_valid); end
    n_vec++; if (bus_if.settled !== 1'b0) begin n_err++; $display("FAIL reset_settled got=%0b required=0", bus_if.settled); end
    n_vec++; if (bus_if.match !== 1'b0) begin n_err++; $display("FAIL reset_match got=%0b required=0", bus_if.match); end
    n_vec++; if (bus_if.greater !== 1'b0) begin n_err++; $display("FAIL reset_greater got=%0b required=0", bus_if.greater); end
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    bus_if.enable = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      run_samples(GATE_LEN, 0, 12, 0, 4);
      n_vec++; if (bus_if.freq !== 16'(10 * w)) begin n_err++; $display("FAIL ramp_freq w=%0d got=%0d required=%0d", w, bus_if.freq, 10 * w); end
      n_vec++; if (bus_if.settled !== (w == 4)) begin n_err++; $display("FAIL ramp_settled w=%0d got=%0b required=%0b", w, bus_if.settled, (w == 4)); end
    end
  endtask

  task automatic test_match();
    n_vec++; if (bus_if.match !== 1'b1) begin n_err++; $display("FAIL match_tol5 got=%0b required=1", bus_if.match); end
    n_vec++; if (bus_if.greater !== 1'b0) begin n_err++; $display("FAIL greater_40 got=%0b required=0", bus_if.greater); end
    bus_if.tolerance = 16'd3;
    n_vec++; if (bus_if.match !== 1'b1) begin n_err++; $display("FAIL match_hold got=%0b required=1", bus_if.match); end
    run_samples(GATE_LEN, 0, 12, 0, 4);
    n_vec++; if (bus_if.match !== 1'b0) begin n_err++; $display("FAIL match_tol3 got=%0b required=0", bus_if.match); end
  endtask

  task automatic test_step();
    for (int w = 1; w <= 4; w++) begin
      run_samples(GATE_LEN, 0, 6, 0, 4);
      n_vec++; if (bus_if.freq !== 16'(40 + 10 * w)) begin n_err++; $display("FAIL step_freq w=%0d got=%0d required=%0d", w, bus_if.freq, 40 + 10 * w); end
      n_vec++; if (bus_if.greater !== 1'b1) begin n_err++; $display("FAIL step_greater w=%0d got=%0b required=1", w, bus_if.greater); end
    end
  endtask

  task automatic test_below_hyst();
    for (int w = 1; w <= 4; w++) begin
      run_samples(GATE_LEN, 1, 0, 0, 4);
      n_vec++; if (bus_if.freq !== 16'(80 - 20 * w)) begin n_err++; $display("FAIL decay_freq w=%0d got=%0d required=%0d", w, bus_if.freq, 80 - 20 * w); end
    end
    n_vec++; if (bus_if.match !== 1'b0) begin n_err++; $display("FAIL decay_match got=%0b required=0", bus_if.match); end
  endtask

  task automatic test_closing_edge();
    pulse_reset();
    run_samples(GATE_LEN, 0, 12, 1, 4);
    n_vec++; if (bus_if.freq !== 16'd11) begin n_err++; $display("FAIL closing_edge_w1 got=%0d required=11", bus_if.freq); end
    run_samples(GATE_LEN, 0, 12, 1, 4);
    n_vec++; if (bus_if.freq !== 16'd21) begin n_err++; $display("FAIL closing_edge_w2 got=%0d required=21", bus_if.freq); end
  endtask

  task automatic test_reset_mid();
    run_samples(60, 0, 12, 0, 4);
    pulse_reset();
    n_vec++; if (bus_if.freq !== 16'd0) begin n_err++; $display("FAIL midreset_freq got=%0d required=0", bus_if.freq); end
    n_vec++; if (bus_if.settled !== 1'b0) begin n_err++; $display("FAIL midreset_settled got=%0b required=0", bus_if.settled); end
    run_samples(GATE_LEN, 0, 12, 0, 4);
    n_vec++; if (bus_if.freq !== 16'd10) begin n_err++; $display("FAIL post_reset_freq got=%0d required=10", bus_if.freq); end
  endtask

  task automatic test_enable_drop();
    int fv0;
    run_samples(60, 0, 12, 0, 4);
    @(negedge clk);
    bus_if.enable = 1'b0;
    m_high = 0; m_samp = 0; m_cross = 0;
    run_samples(24, 0, 12, 0, 4);
    bus_if.enable = 1'b1;
    fv0 = n_fv;
    run_samples(GATE_LEN - 1, 0, 12, 0, 4);
    n_vec++; if (n_fv !== fv0) begin n_err++; $display("FAIL enable_early_pulse got=%0d required=%0d", n_fv - fv0, 0); end
    drive(sq(GATE_LEN - 1, 12, 0), 4);
    @(negedge clk);
    bus_if.sample_valid = 1'b0;
    n_vec++; if (n_fv !== fv0 + 1) begin n_err++; $display("FAIL enable_full_window pulses got=%0d required=1", n_fv - fv0); end
    n_vec++; if (bus_if.freq !== 16'd20) begin n_err++; $display("FAIL enable_freq got=%0d required=20", bus_if.freq); end
  endtask

  task automatic test_back_to_back();
    run_samples(2 * GATE_LEN, 0, 12, 0, 1);
    n_vec++; if (bus_if.freq !== 16'd40) begin n_err++; $display("FAIL b2b_freq got=%0d required=40", bus_if.freq); end
    n_vec++; if (bus_if.settled !== 1'b1) begin n_err++; $display("FAIL b2b_settled got=%0b required=1", bus_if.settled); end
  endtask

  initial begin
    bus_if.enable        = 1'b0;
    bus_if.sample_valid  = 1'b0;
    bus_if.sample        = '0;
    bus_if.expected_freq = 16'd44;
    bus_if.tolerance     = 16'd5;
    model_reset();
    fork
      monitor_loop();
    join_none
    test_reset();
    test_ramp();
    test_match();
    test_step();
    test_below_hyst();
    test_closing_edge();
    test_reset_mid();
    test_enable_drop();
    test_back_to_back();
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tuner_pitch_meter.md
Name: tuner_pitch_meter

Overview:
Parametrised pitch-measurement core for the tuner. It replaces the single-shot frequency counter and the separate range comparator.
- Counts rising zero crossings of a signed audio stream, with hysteresis, over a fixed sample-count gate window.
- Scales the count to Hz and smooths it with a 2^AVG_LOG2-deep moving average.
- Compares the result to an expected frequency within a tolerance.
- Sits between the audio codec read path and the HEX/LED display logic.

Parameters:
- SAMPLE_W, 24, audio sample width (signed two's complement).
- FREQ_W, 16, width of all frequency values, in Hz.
- SAMPLE_RATE, 48000, codec sample rate in Hz.
- GATE_SHIFT, 2, gate window length GATE_LEN = SAMPLE_RATE >> GATE_SHIFT samples. Resolution is 2^GATE_SHIFT Hz. SAMPLE_RATE must be divisible by 2^GATE_SHIFT.
- HYST, 24'd4096, hysteresis threshold magnitude (positive, SAMPLE_W bits).
- AVG_LOG2, 2, log2 of the moving-average depth. A value of 0 disables averaging.

Ports:
- clk, input, 1, system clock (CLOCK_50).
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, measurement enable.
- sample_valid, input, 1, one-cycle strobe marking a new sample (codec read handshake).
- sample, input, SAMPLE_W, signed audio sample.
- expected_freq, input, FREQ_W, target frequency in Hz.
- tolerance, input, FREQ_W, allowed absolute error in Hz.
- freq, output, FREQ_W, averaged measured frequency in Hz.
- freq_valid, output, 1, one-cycle pulse when freq/match/greater update.
- settled, output, 1, high once the average buffer holds 2^AVG_LOG2 real windows.
- match, output, 1, |freq - expected_freq| <= tolerance.
- greater, output, 1, freq >= expected_freq.

Behaviour:
- Reset:
  - reset is synchronous, active-high, and dominates every other input.
  - It clears freq, freq_valid, settled, match and greater to 0.
  - It clears the ring buffer, running sum, sample counter, crossing counter and fill counter to 0.
  - It sets the sign state to LOW.
  - Reset in mid-window discards that window entirely.
- Sign state (2 states, LOW/HIGH), updated only on cycles where sample_valid=1 and enable=1:
  - LOW -> HIGH when sample > +HYST (signed compare).
  - HIGH -> LOW when sample < -HYST.
  - Otherwise the state holds.
  - Each LOW -> HIGH transition counts as one crossing.
- Gate:
  - The sample counter increments on each accepted strobe.
  - The strobe that brings the count to GATE_LEN is the closing strobe. That sample is included, and any crossing it produces counts in the closing window.
  - Sample and crossing counters restart at 0 on the next cycle.
  - The crossing counter saturates at all-ones and never wraps.
- Raw frequency:
  - raw = crossings << GATE_SHIFT.
  - If raw overflows FREQ_W, it saturates to 2^FREQ_W-1.
- Pipeline, with cycle N = the closing strobe:
  - N+1: raw is written to the ring slot at the write pointer. sum = sum - old_slot + raw, with width FREQ_W+AVG_LOG2 so it never overflows. The pointer wraps modulo 2^AVG_LOG2. The fill counter increments and saturates at 2^AVG_LOG2.
  - N+2:
    - freq = sum >> AVG_LOG2.
    - match and greater are computed from the new freq and the current expected_freq/tolerance.
    - freq_valid = 1 for exactly one cycle.
    - settled = 1 if the fill counter equals 2^AVG_LOG2.
- Until the buffer is full, empty slots count as 0, so freq ramps up.
- Between updates, freq, match, greater and settled hold their values. They are not recomputed when expected_freq changes.
- match uses unsigned absolute difference with no wrap: diff = (freq >= exp) ? freq - exp : exp - freq.
- enable=0:
  - Strobes are ignored.
  - Sample and crossing counters clear to 0 and the sign state goes to LOW, so any partial window is discarded.
  - Any pipeline stage already in flight still completes.
  - The ring buffer, sum and outputs hold.
  - Re-enabling starts a fresh window.
- A sample_valid strobe during cycles N+1 or N+2 is accepted normally into the new window. The pipeline does not stall.

Test Plan:
1. Reset, then enable=1 with a ±8M square wave of period 120 samples, one strobe every 4 clk. Expected:
   - Window 1: freq=100, settled=0.
   - Windows 2/3: freq=200/300.
   - Window 4: freq=400, settled=1.
   - freq_valid fires exactly 2 clk after each closing strobe.
2. Settled at 400 Hz, expected_freq=440, tolerance=50 -> match=1, greater=0. Then tolerance=30 with the same input -> match=0 on the next freq_valid.
3. Change the input period to 60 samples (800 Hz) after settling -> freq steps 500, 600, 700, 800. greater=1 from the first update onward.
4. Triangle wave of amplitude ±2000 (< HYST) at 1 kHz -> no crossings; freq decays to 0 over 4 windows, match=0 for expected 440.
5. Crossing on the closing strobe: arrange the 100th rising edge on sample 12000 -> that window's raw=400, and the next window is not credited with it.
6. Pulse reset at sample 6000 of window 3, and separately drop enable for 100 clk mid-window -> reset clears freq and settled to 0 immediately, and the first post-reset freq is 100. The enable drop discards the partial window, and the next freq_valid follows a full GATE_LEN window.
